// File: rtl/instr_fetch_issue_pkg.sv
// Shared RISC definitions used by the instruction fetch/issue unit.
//  - Opcode constants for the control decoder's instruction set.
//  - Fetch FSM state encoding.
//  - is_legal_op(): membership test against the implemented opcode set.
// No ports (package only).
package risc_pkg;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_SLT = 4'h7;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'hA;
  localparam logic [3:0] OP_BNE = 4'hE;
  localparam logic [3:0] OP_JMP = 4'hF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    ISSUE   = 3'd2,
    RESOLVE = 3'd3,
    HALT    = 3'd4
  } fetch_state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT,
      OP_LW, OP_SW, OP_BNE, OP_JMP: legal = 1'b1;
      default:                      legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/instr_fetch_issue_if.sv
// Bus bundle for the instruction fetch/issue unit.
//  Instruction memory : imem_req, imem_addr (unit -> mem); imem_ack, imem_rdata (mem -> unit)
//  Issue to datapath  : opCode, instr, instr_valid (unit -> dp); instr_ready (dp -> unit)
//  Resolve feedback   : ex_done, branch, jump, alu_zero (decoder/ALU -> unit)
//  Status             : pc, illegal (unit -> observers)
// modport master = fetch/issue unit side, modport slave = environment side.
interface instr_fetch_issue_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic [3:0]         opCode;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic               ex_done;
  logic               branch;
  logic               jump;
  logic               alu_zero;
  logic [ADDR_W-1:0]  pc;
  logic               illegal;

  modport master (
    output imem_req, imem_addr, opCode, instr, instr_valid, pc, illegal,
    input  imem_ack, imem_rdata, instr_ready, ex_done, branch, jump, alu_zero
  );

  modport slave (
    input  imem_req, imem_addr, opCode, instr, instr_valid, pc, illegal,
    output imem_ack, imem_rdata, instr_ready, ex_done, branch, jump, alu_zero
  );

endinterface

// File: rtl/instr_fetch_issue_pc_next_calc.sv
// Combinational next-PC selection for the fetch/issue unit.
//  pc       in   ADDR_W   current PC
//  instr    in   INSTR_W  instruction being resolved (target in low bits, BNE offset in [3:0])
//  branch   in   1        BNE decoded
//  jump     in   1        jump decoded (wins over branch)
//  alu_zero in   1        ALU zero flag; BNE taken when 0
//  next_pc  out  ADDR_W   PC for the next fetch, modulo 2^ADDR_W
module pc_next_calc #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               branch,
  input  logic               jump,
  input  logic               alu_zero,
  output logic [ADDR_W-1:0]  next_pc
);

  logic signed [ADDR_W-1:0] br_off;
  logic        [ADDR_W-1:0] seq_pc;

  // Upper instruction bits carry opcode/register fields, irrelevant to PC selection.
  logic unused_instr_hi;
  assign unused_instr_hi = ^instr[INSTR_W-1:ADDR_W];

  assign br_off = $signed({{(ADDR_W-4){instr[3]}}, instr[3:0]});
  assign seq_pc = pc + ADDR_W'(1);

  always_comb begin
    next_pc = seq_pc;
    if (jump)
      next_pc = instr[ADDR_W-1:0];
    else if (branch && !alu_zero)
      next_pc = seq_pc + $unsigned(br_off);
  end

endmodule

// File: rtl/instr_fetch_issue.sv
// Instruction fetch/issue unit: fetches one word at a time, issues it to the
// datapath with a valid/ready handshake, then waits for execution to finish
// before computing the next PC. One instruction in flight.
//  clock    in   1  system clock, all state on posedge
//  reset_n  in   1  synchronous active-low reset
//  bus      master modport of instr_fetch_issue_if (imem, issue, resolve, status)
// Build option: INSTR_FETCH_ILLEGAL_TRAP_EN -- when defined, an unimplemented
// opcode sets the sticky illegal flag and parks the unit in HALT until reset.
module instr_fetch_issue
  import risc_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset_n,
  instr_fetch_issue_if.master bus
);

  fetch_state_e       state_q, state_n;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  next_pc;
  logic [INSTR_W-1:0] instr_q;
  logic               instr_load;
  logic               pc_load;

  pc_next_calc #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_pc_next_calc (
    .pc       (pc_q),
    .instr    (instr_q),
    .branch   (bus.branch),
    .jump     (bus.jump),
    .alu_zero (bus.alu_zero),
    .next_pc  (next_pc)
  );

`ifdef INSTR_FETCH_ILLEGAL_TRAP_EN
  logic trap_set;
  logic illegal_q;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n)
      state_q <= IDLE;
    else
      state_q <= state_n;
  end

  always_comb begin
    state_n    = state_q;
    instr_load = 1'b0;
    pc_load    = 1'b0;
`ifdef INSTR_FETCH_ILLEGAL_TRAP_EN
    trap_set   = 1'b0;
`endif
    case (state_q)
      IDLE:    state_n = FETCH;
      FETCH: begin
        if (bus.imem_ack) begin
          instr_load = 1'b1;
`ifdef INSTR_FETCH_ILLEGAL_TRAP_EN
          if (!is_legal_op(bus.imem_rdata[INSTR_W-1 -: 4])) begin
            trap_set = 1'b1;
            state_n  = HALT;
          end else begin
            state_n  = ISSUE;
          end
`else
          state_n = ISSUE;
`endif
        end
      end
      ISSUE:   if (bus.instr_ready) state_n = RESOLVE;
      RESOLVE: begin
        // branch/jump/alu_zero only mean anything alongside ex_done.
        if (bus.ex_done) begin
          pc_load = 1'b1;
          state_n = FETCH;
        end
      end
      HALT:    state_n = HALT;
      default: state_n = IDLE;
    endcase
  end

  // Instruction and PC registers; reset clears them so a reset mid-fetch
  // abandons the instruction and ignores any late ack.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      if (instr_load) instr_q <= bus.imem_rdata;
      if (pc_load)    pc_q    <= next_pc;
    end
  end

`ifdef INSTR_FETCH_ILLEGAL_TRAP_EN
  always_ff @(posedge clock) begin
    if (!reset_n)
      illegal_q <= 1'b0;
    else if (trap_set)
      illegal_q <= 1'b1;
  end
  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.imem_req    = (state_q == FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state_q == ISSUE);
  assign bus.opCode      = instr_q[INSTR_W-1 -: 4];
  assign bus.instr       = instr_q;
  assign bus.pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Self-checking bench for instr_fetch_issue: table of instruction records driven
// through fetch/issue/resolve with a scoreboard on issued words, plus hand-written
// reset-mid-fetch and illegal-opcode sequences.
module tb_instr_fetch_issue;

  logic clock;
  logic reset_n;
  int   npass;
  int   ntotal;

  instr_fetch_issue_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

  instr_fetch_issue #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached, required $finish before it");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [15:0] word;
    logic        br;
    logic        jp;
    logic        az;
    int          rdly;
    logic [7:0]  addr;
    logic [7:0]  nxt;
  } vec_t;

  vec_t        vecs[12];
  logic [15:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk("req_seen", 32'(bus.imem_req), 32'd1);
  endtask

  task automatic run_instr(input vec_t v);
    logic [15:0] exp;
    wait_req();
    chk("imem_addr", 32'(bus.imem_addr), 32'(v.addr));
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = v.word;
    sb.push_back(v.word);
    @(posedge clock); #1;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'h0;
    chk("req_drop", 32'(bus.imem_req), 32'd0);
    for (int i = 0; i < v.rdly; i++) begin
      chk("valid_hold", 32'(bus.instr_valid), 32'd1);
      chk("instr_hold", 32'(bus.instr), 32'(v.word));
      chk("pc_hold", 32'(bus.pc), 32'(v.addr));
      // Stray ex_done with jump while not resolving must not move the PC.
      bus.ex_done = 1'b1;
      bus.jump    = 1'b1;
      @(posedge clock); #1;
      bus.ex_done = 1'b0;
      bus.jump    = 1'b0;
    end
    chk("valid", 32'(bus.instr_valid), 32'd1);
    chk("sb_size", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      chk("sb_instr", 32'(bus.instr), 32'(exp));
      chk("sb_opcode", 32'(bus.opCode), 32'(exp[15:12]));
    end
    bus.instr_ready = 1'b1;
    @(posedge clock); #1;
    bus.instr_ready = 1'b0;
    chk("valid_drop", 32'(bus.instr_valid), 32'd0);
    bus.ex_done  = 1'b1;
    bus.branch   = v.br;
    bus.jump     = v.jp;
    bus.alu_zero = v.az;
    @(posedge clock); #1;
    bus.ex_done  = 1'b0;
    bus.branch   = 1'b0;
    bus.jump     = 1'b0;
    bus.alu_zero = 1'b0;
    chk("next_pc", 32'(bus.pc), 32'(v.nxt));
    chk("refetch_req", 32'(bus.imem_req), 32'd1);
  endtask

  initial begin
    vec_t v;
    npass  = 0;
    ntotal = 0;
    //            word      br    jp    az   rdly addr   next
    vecs[0]  = '{16'h2123, 1'b0, 1'b0, 1'b0, 0, 8'h00, 8'h01};
    vecs[1]  = '{16'h2123, 1'b0, 1'b0, 1'b0, 0, 8'h01, 8'h02};
    vecs[2]  = '{16'h2123, 1'b0, 1'b0, 1'b0, 0, 8'h02, 8'h03};
    vecs[3]  = '{16'hF0A7, 1'b1, 1'b1, 1'b0, 0, 8'h03, 8'hA7};
    vecs[4]  = '{16'hF005, 1'b0, 1'b1, 1'b0, 0, 8'hA7, 8'h05};
    vecs[5]  = '{16'hE12F, 1'b1, 1'b0, 1'b0, 0, 8'h05, 8'h05};
    vecs[6]  = '{16'hE12F, 1'b1, 1'b0, 1'b1, 0, 8'h05, 8'h06};
    vecs[7]  = '{16'hF0FF, 1'b0, 1'b1, 1'b0, 0, 8'h06, 8'hFF};
    vecs[8]  = '{16'h2123, 1'b0, 1'b0, 1'b0, 5, 8'hFF, 8'h00};
    vecs[9]  = '{16'hE128, 1'b1, 1'b0, 1'b0, 0, 8'h00, 8'hF9};
    vecs[10] = '{16'hE127, 1'b1, 1'b0, 1'b0, 0, 8'hF9, 8'h01};
    vecs[11] = '{16'hE127, 1'b1, 1'b0, 1'b1, 2, 8'h01, 8'h02};

    reset_n         = 1'b0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 16'h0;
    bus.instr_ready = 1'b0;
    bus.ex_done     = 1'b0;
    bus.branch      = 1'b0;
    bus.jump        = 1'b0;
    bus.alu_zero    = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_opcode", 32'(bus.opCode), 32'd0);
    chk("rst_instr", 32'(bus.instr), 32'd0);
    chk("rst_pc", 32'(bus.pc), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("idle_to_fetch", 32'(bus.imem_req), 32'd1);

    for (int i = 0; i < 12; i++) run_instr(vecs[i]);

    // Reset while a fetch is being acknowledged; ack held through reset.
    wait_req();
    chk("mid_addr", 32'(bus.imem_addr), 32'h02);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 16'h2123;
    reset_n        = 1'b0;
    @(posedge clock); #1;
    chk("mid_rst_req", 32'(bus.imem_req), 32'd0);
    chk("mid_rst_pc", 32'(bus.pc), 32'd0);
    chk("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("mid_rst_instr", 32'(bus.instr), 32'd0);
    @(posedge clock); #1;
    chk("late_ack_valid", 32'(bus.instr_valid), 32'd0);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'h0;
    reset_n        = 1'b1;
    chk("rel_idle_req", 32'(bus.imem_req), 32'd0);
    @(posedge clock); #1;
    chk("refetch_addr", 32'(bus.imem_addr), 32'd0);
    v = '{16'h2123, 1'b0, 1'b0, 1'b0, 0, 8'h00, 8'h01};
    run_instr(v);

`ifdef INSTR_FETCH_ILLEGAL_TRAP_EN
    wait_req();
    chk("trap_addr", 32'(bus.imem_addr), 32'h01);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 16'h3000;
    @(posedge clock); #1;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'h0;
    chk("trap_illegal", 32'(bus.illegal), 32'd1);
    for (int i = 0; i < 20; i++) begin
      chk("halt_req", 32'(bus.imem_req), 32'd0);
      chk("halt_valid", 32'(bus.instr_valid), 32'd0);
      chk("halt_pc", 32'(bus.pc), 32'h01);
      bus.ex_done = 1'b1;
      bus.jump    = 1'b1;
      @(posedge clock); #1;
      bus.ex_done = 1'b0;
      bus.jump    = 1'b0;
    end
    chk("halt_illegal_sticky", 32'(bus.illegal), 32'd1);
`else
    v = '{16'h3000, 1'b0, 1'b0, 1'b0, 0, 8'h01, 8'h02};
    run_instr(v);
    chk("no_trap_illegal", 32'(bus.illegal), 32'd0);
`endif

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
